// File: rtl/nrd_div_pkg.sv
// Shared types and sizing helpers for the non-restoring sequential divider.
package nrd_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int calc_qw(input int width, input int frac_bits);
        return width + frac_bits;
    endfunction

    // Counter must hold values 0..n-1.
    function automatic int calc_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nrd_addsub.sv
// Single shared adder/subtractor used for every non-restoring iteration.
module nrd_addsub #(
    parameter int N = 26
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/nrd_seq_divider.sv
// Iterative unsigned non-restoring divider, one quotient bit per clock.
// NRD_SEQ_DIVIDER_REM_CORRECT_EN adds a FIX cycle producing the true remainder.
module nrd_seq_divider
    import nrd_div_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int FRAC_BITS = 24
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                dividend,
    input  logic [WIDTH-1:0]                divisor,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH+FRAC_BITS-1:0]      quotient,
    output logic [WIDTH-1:0]                remainder,
    output logic                            div_by_zero
);

    localparam int QW = calc_qw(WIDTH, FRAC_BITS);
    localparam int CW = calc_cnt_w(QW);
    localparam int AW = WIDTH + 2;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH-1:0] d_q;
    logic [AW-1:0]   a_q;
    logic [QW-1:0]   q_q;
    logic            dz_q;

    logic [AW-1:0]   a_sh;
    logic [AW-1:0]   as_a;
    logic            as_sub;
    logic [AW-1:0]   as_sum;
    logic            last_iter;

    assign a_sh      = {a_q[AW-2:0], q_q[QW-1]};
    assign last_iter = (cnt_q == CW'(QW - 1));

`ifdef NRD_SEQ_DIVIDER_REM_CORRECT_EN
    // FIX reuses the adder to add D back onto a negative remainder.
    assign as_a   = (state_q == FIX) ? a_q  : a_sh;
    assign as_sub = (state_q == FIX) ? 1'b0 : ~a_q[AW-1];
`else
    assign as_a   = a_sh;
    assign as_sub = ~a_q[AW-1];
`endif

    nrd_addsub #(.N(AW)) u_addsub (
        .a   (as_a),
        .b   ({2'b00, d_q}),
        .sub (as_sub),
        .sum (as_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = (divisor == '0) ? DONE : RUN;
`ifdef NRD_SEQ_DIVIDER_REM_CORRECT_EN
            RUN:  if (last_iter) state_d = FIX;
`else
            RUN:  if (last_iter) state_d = DONE;
`endif
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            d_q   <= '0;
            a_q   <= '0;
            q_q   <= '0;
            dz_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    d_q   <= divisor;
                    cnt_q <= '0;
                    dz_q  <= (divisor == '0);
                    if (divisor == '0) begin
                        q_q <= '1;
                        a_q <= {2'b00, dividend};
                    end else begin
                        q_q <= {dividend, {FRAC_BITS{1'b0}}};
                        a_q <= '0;
                    end
                end
                RUN: begin
                    a_q   <= as_sum;
                    q_q   <= {q_q[QW-2:0], ~as_sum[AW-1]};
                    cnt_q <= cnt_q + 1'b1;
                end
`ifdef NRD_SEQ_DIVIDER_REM_CORRECT_EN
                FIX: if (a_q[AW-1]) a_q <= as_sum;
`endif
                default: ;
            endcase
        end
    end

    assign quotient    = q_q;
    assign div_by_zero = dz_q;
`ifdef NRD_SEQ_DIVIDER_REM_CORRECT_EN
    assign remainder   = a_q[WIDTH-1:0];
`else
    assign remainder   = dz_q ? a_q[WIDTH-1:0] : '0;
`endif

endmodule

// File: tb/tb_nrd_seq_divider.sv
// Scoreboard bench for nrd_seq_divider at default WIDTH=24, FRAC_BITS=24.
module tb_nrd_seq_divider;

    localparam int W  = 24;
    localparam int F  = 24;
    localparam int QW = W + F;
`ifdef NRD_SEQ_DIVIDER_REM_CORRECT_EN
    localparam int LAT    = QW + 1;
    localparam bit REM_EN = 1'b1;
`else
    localparam int LAT    = QW;
    localparam bit REM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [QW-1:0] quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [QW-1:0] q;
        logic [W-1:0]  r;
        logic          dz;
    } exp_t;

    exp_t sb[$];

    nrd_seq_divider #(.WIDTH(W), .FRAC_BITS(F)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv);
        exp_t e;
        logic [QW-1:0] num;
        num = {dd, {F{1'b0}}};
        if (dv == '0) begin
            e.q  = '1;
            e.r  = dd;
            e.dz = 1'b1;
        end else begin
            e.q  = num / QW'(dv);
            e.r  = REM_EN ? W'(num % QW'(dv)) : '0;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic do_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input int hold);
        exp_t e;
        int   cyc;
        int   want_lat;
        sb.push_back(model(dd, dv));
        want_lat = (dv == '0) ? 0 : LAT;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_idle: got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout: got %b after %0d cycles want 1", out_valid, cyc);
            return;
        end
        checks++;
        if (cyc != want_lat) begin
            errors++;
            $display("FAIL latency %h/%h: got %0d want %0d", dd, dv, cyc, want_lat);
        end
        checks++;
        if (quotient !== e.q) begin
            errors++;
            $display("FAIL quotient %h/%h: got %h want %h", dd, dv, quotient, e.q);
        end
        checks++;
        if (remainder !== e.r) begin
            errors++;
            $display("FAIL remainder %h/%h: got %h want %h", dd, dv, remainder, e.r);
        end
        checks++;
        if (div_by_zero !== e.dz) begin
            errors++;
            $display("FAIL div_by_zero %h/%h: got %b want %b", dd, dv, div_by_zero, e.dz);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_done: got %b want 0", in_ready);
        end
        repeat (hold) begin
            @(negedge clk);
            checks++;
            if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz ||
                out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: got q=%h r=%h dz=%b ov=%b ir=%b want q=%h r=%h dz=%b ov=1 ir=0",
                         quotient, remainder, div_by_zero, out_valid, in_ready, e.q, e.r, e.dz);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 ||
            remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL %s: got ir=%b ov=%b q=%h r=%h dz=%b want ir=1 ov=0 q=0 r=0 dz=0",
                     tag, in_ready, out_valid, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("after_release");
    endtask

    task automatic test_basic();
        do_op(24'h000001, 24'h000002, 0);
        do_op(24'h00000A, 24'h000003, 0);
        do_op(24'hFFFFFF, 24'h000001, 0);
        do_op(24'h000001, 24'hFFFFFF, 0);
        do_op(24'hFFFFFF, 24'hFFFFFF, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            do_op(W'($urandom), W'($urandom_range(1, 255)) | W'($urandom), 0);
        end
    endtask

    task automatic test_div_zero();
        do_op(24'h123456, 24'h000000, 0);
        do_op(24'h000000, 24'h000000, 0);
    endtask

    task automatic test_hold();
        do_op(24'h00000A, 24'h000003, 10);
    endtask

    task automatic test_abort();
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 24'h000123;
        divisor  = 24'h000007;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(24'h000006, 24'h000003, 0);
    endtask

    task automatic test_back_to_back();
        do_op(24'h000007, 24'h000002, 0);
        do_op(24'h000000, 24'h000005, 0);
        do_op(24'h800000, 24'h000000, 2);
        do_op(24'h000009, 24'h000004, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_div_zero();
        test_hold();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
